// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Purpose  : Parametrised multi-port register file with prioritised writes,
//            optional write-to-read bypass and a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
  parameter int WIDTH  = 128,
  parameter int SIZE   = 128,
  parameter int NUM_RD = 6,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int LOGSIZE = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR-1:0][LOGSIZE-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]      wr_data,
  input  logic [NUM_RD-1:0][LOGSIZE-1:0]    rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]      rd_data,
  output logic                              busy
);

  localparam logic [LOGSIZE:0]   c_size = (LOGSIZE+1)'(SIZE);
  localparam logic [LOGSIZE-1:0] c_last = LOGSIZE'(SIZE - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [LOGSIZE-1:0]          r_clr_ptr, w_clr_ptr_nxt;
  logic [WIDTH-1:0]            r_mem [SIZE];
  logic [NUM_RD-1:0][WIDTH-1:0] r_rd_data;
  logic [NUM_RD-1:0][WIDTH-1:0] w_rd_nxt;
  logic [NUM_WR-1:0]           w_wr_ok;

  function automatic logic f_in_range(input logic [LOGSIZE-1:0] a);
    return ({1'b0, a} < c_size);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    if (r_state == S_CLEAR) begin
      w_clr_ptr_nxt = r_clr_ptr + LOGSIZE'(1);
      if (r_clr_ptr == c_last) begin
        w_state_nxt   = S_READY;
        w_clr_ptr_nxt = '0;
      end
    end
  end

  assign busy = (r_state == S_CLEAR);

  // Out-of-range writes are filtered here so they can neither land nor win a conflict.
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      w_wr_ok[p] = wr_en[p] && f_in_range(wr_addr[p]);
    end
  end

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_wr_ok[p]) r_mem[wr_addr[p]] <= wr_data[p];
        end
      end
    end
  end

  always_comb begin
    w_rd_nxt = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (f_in_range(rd_addr[i])) w_rd_nxt[i] = r_mem[rd_addr[i]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_wr_ok[p] && (wr_addr[p] == rd_addr[i])) w_rd_nxt[i] = wr_data[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_CLEAR)) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_nxt;
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Purpose  : Scoreboard bench for register_file_mp (bypass, no-bypass, SIZE=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                   rst     [3];
    logic [1:0]             wr_en   [3];
    logic [1:0][6:0]        wr_addr [3];
    logic [1:0][127:0]      wr_data [3];
    logic [5:0][6:0]        rd_addr [3];
    logic [5:0][127:0]      rd_data [3];
    logic                   busy    [3];

    register_file_mp #(.BYPASS(1)) u_a (
        .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .busy(busy[0]));
    register_file_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .busy(busy[1]));
    register_file_mp #(.SIZE(100)) u_c (
        .clk(clk), .rst(rst[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .busy(busy[2]));

    typedef struct {
        int           due;
        int           d;
        bit           is_busy;
        int           port;
        logic [127:0] val;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every expectation becomes due at a specific cycle and is checked mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t         e;
            logic [127:0] act;
            e   = sb.pop_front();
            act = e.is_busy ? {127'b0, busy[e.d]} : rd_data[e.d][e.port];
            total++;
            if (act !== e.val || e.due != cyc) begin
                bad++;
                $display("FAIL %s dut%0d port%0d cyc%0d: got %h want %h", e.name, e.d, e.port, cyc, act, e.val);
            end
        end
    end

    function automatic int sz(input int d);
        return (d == 2) ? 100 : 128;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) wr_en[d] = '0;
    endtask

    task automatic expect_rd(input int d, input int port, input logic [127:0] v, input string n);
        sb.push_back('{cyc + 1, d, 1'b0, port, v, n});
    endtask

    task automatic expect_busy(input int d, input logic b, input string n);
        sb.push_back('{cyc + 1, d, 1'b1, 0, {127'b0, b}, n});
    endtask

    task automatic rd(input int d, input int port, input logic [6:0] a, input logic [127:0] v, input string n);
        rd_addr[d][port] = a;
        expect_rd(d, port, v, n);
    endtask

    task automatic wr(input int d, input int p, input logic [6:0] a, input logic [127:0] v);
        wr_en[d][p]   = 1'b1;
        wr_addr[d][p] = a;
        wr_data[d][p] = v;
    endtask

    // One-cycle reset pulse on the masked DUTs followed by the whole clear sequence.
    task automatic do_reset(input bit [2:0] mask, input int wr_steps);
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) begin
                rst[d] = 1'b1;
                for (int i = 0; i < 6; i++) expect_rd(d, i, '0, "rst_rd");
                expect_busy(d, 1'b1, "rst_busy");
            end
        end
        tick();
        for (int d = 0; d < 3; d++) if (mask[d]) rst[d] = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (mask[d]) begin
                    expect_busy(d, k < sz(d), "clr_busy");
                    if (k <= sz(d)) expect_rd(d, 0, '0, "clr_rd");
                end
            end
            if (k <= wr_steps) wr(0, 0, 7'd2, 128'hF);
            tick();
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; wr_en[d] = '0; wr_addr[d] = '0; wr_data[d] = '0; rd_addr[d] = '0;
        end
        do_reset(3'b111, 0);
        total++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL init_busy_low: busy=%b%b%b", busy[0], busy[1], busy[2]);
        end

        // Reset/clear of a populated file
        wr(0, 0, 7'd5, 128'hAA);
        tick();
        rd(0, 0, 7'd5, 128'hAA, "pre_aa");
        tick();
        do_reset(3'b001, 0);
        for (int c = 0; c < 22; c++) begin
            for (int i = 0; i < 6; i++) begin
                if (6 * c + i < 128) rd(0, i, 7'(6 * c + i), '0, "sweep_a");
            end
            tick();
        end

        // Basic write then read
        wr(0, 0, 7'd10, 128'h1234);
        tick();
        rd(0, 0, 7'd10, 128'h1234, "basic");
        for (int i = 1; i < 6; i++) rd(0, i, 7'd11, '0, "basic_other");
        tick();

        // Write conflict and bypass
        wr(0, 0, 7'd7, 128'h11);
        wr(0, 1, 7'd7, 128'h22);
        rd(0, 0, 7'd7, 128'h22, "conf_byp");
        rd(0, 1, 7'd10, 128'h1234, "conf_other");
        tick();
        rd(0, 2, 7'd7, 128'h22, "conf_mem");
        wr(0, 1, 7'd20, 128'h33);
        wr(0, 0, 7'd21, 128'h44);
        rd(0, 3, 7'd20, 128'h33, "byp_p1");
        rd(0, 4, 7'd21, 128'h44, "byp_p0");
        tick();
        rd(0, 5, 7'd20, 128'h33, "byp_mem");
        tick();

        // No-bypass instance
        wr(1, 0, 7'd3, 128'h5);
        tick();
        wr(1, 0, 7'd3, 128'h9);
        rd(1, 0, 7'd3, 128'h5, "nb_old");
        tick();
        rd(1, 0, 7'd3, 128'h9, "nb_new");
        wr(1, 0, 7'd7, 128'h11);
        wr(1, 1, 7'd7, 128'h22);
        rd(1, 1, 7'd7, '0, "nb_conf_old");
        tick();
        rd(1, 1, 7'd7, 128'h22, "nb_conf_mem");
        tick();

        // Reset asserted mid-clear, writes attempted during CLEAR
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            expect_busy(0, 1'b1, "mid_busy");
            tick();
        end
        do_reset(3'b001, 100);
        rd(0, 0, 7'd2, '0, "clr_wr_ignored");
        rd(0, 1, 7'd10, '0, "clr_10");
        rd(0, 2, 7'd7, '0, "clr_7");
        tick();
        total++;
        if (rd_data[0][0] !== 128'h0) begin
            bad++;
            $display("FAIL direct_clr_wr_ignored: got %h", rd_data[0][0]);
        end
        wr(0, 0, 7'd2, 128'hF);
        tick();
        rd(0, 0, 7'd2, 128'hF, "post_clr_wr");
        tick();
        total++;
        if (rd_data[0][0] !== 128'hF) begin
            bad++;
            $display("FAIL direct_post_clr_wr: got %h", rd_data[0][0]);
        end

        // Non-power-of-2 instance
        wr(2, 0, 7'd99, 128'hBEEF);
        tick();
        wr(2, 0, 7'd110, 128'hDEAD);
        rd(2, 0, 7'd110, '0, "np2_oor_byp");
        rd(2, 1, 7'd99, 128'hBEEF, "np2_last");
        tick();
        rd(2, 0, 7'd110, '0, "np2_oor");
        rd(2, 1, 7'd10, '0, "np2_alias");
        rd(2, 2, 7'd99, 128'hBEEF, "np2_last2");
        rd(2, 3, 7'd0, '0, "np2_zero");
        tick();
        wr(2, 0, 7'd50, 128'h1);
        wr(2, 1, 7'd110, 128'h2);
        rd(2, 0, 7'd50, 128'h1, "np2_oor_nowin");
        tick();
        for (int c = 0; c < 17; c++) begin
            for (int i = 0; i < 6; i++) begin
                if (6 * c + i < 100) begin
                    rd(2, i, 7'(6 * c + i),
                       (6 * c + i == 50) ? 128'h1 : ((6 * c + i == 99) ? 128'hBEEF : 128'h0), "sweep_c");
                end
            end
            tick();
        end
        total++;
        if (busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL direct_np2_busy: got %b", busy[2]);
        end

        tick();
        tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s dut%0d: never checked, want %h", e.name, e.d, e.val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
